// File: rtl/gpa_spi_multi_iface_if.sv
// rtl/gpa_spi_multi_iface_if.sv - request/readback bundle between sequencer word path and SPI engine
// Member names keep the engine's point of view (_i into the engine, _o out of it).
interface gpa_spi_multi_iface_if #(
   parameter int FRAME_W = 24,
   parameter int CSW     = 1
);
   logic [FRAME_W-1:0] data_i;
   logic [CSW-1:0]     cs_sel_i;
   logic               rd_en_i;
   logic               valid_i;
   logic               busy_o;
   logic [FRAME_W-1:0] rd_data_o;
   logic [CSW-1:0]     rd_cs_o;
   logic               rd_valid_o;

   modport master (
      output data_i, cs_sel_i, rd_en_i, valid_i,
      input  busy_o, rd_data_o, rd_cs_o, rd_valid_o
   );

   modport slave (
      input  data_i, cs_sel_i, rd_en_i, valid_i,
      output busy_o, rd_data_o, rd_cs_o, rd_valid_o
   );
endinterface

// File: rtl/gpa_spi_multi_iface.sv
// rtl/gpa_spi_multi_iface.sv - multi-chip-select SPI master (CPOL=0, CPHA=1) for gradient boards
// One frame per accept: SETUP, FRAME_W SCLK periods, HOLD, then an all-high CSn gap.
module gpa_spi_multi_iface #(
   parameter int NCS     = 2,
   parameter int FRAME_W = 24,
   parameter int DIV_W   = 6,
   parameter int CS_GAP  = 2,
   localparam int CSW    = (NCS > 1) ? $clog2(NCS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   gpa_spi_multi_iface_if.slave req,
   input  logic [DIV_W-1:0]    spi_clk_div_i,
   input  logic                clr_err_i,
   output logic                err_o,
   output logic                fhd_clk_o,
   output logic                fhd_sdo_o,
   output logic [NCS-1:0]      fhd_csn_o,
   input  logic                fhd_sdi_i
);
   localparam int GW = $clog2(CS_GAP + 1);
   localparam int CW = (DIV_W > GW) ? DIV_W : GW;
   localparam int BW = $clog2(FRAME_W);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [FRAME_W-1:0] rx_q, rx_d;
   logic [CSW-1:0]     sel_q, sel_d;
   logic               rden_q, rden_d;
   logic               busy_q, busy_d;
   logic [NCS-1:0]     csn_q, csn_d;
   logic               sclk_q, sclk_d;
   logic               sdo_q, sdo_d;
   logic [FRAME_W-1:0] rd_data_q, rd_data_d;
   logic [CSW-1:0]     rd_cs_q, rd_cs_d;
   logic               rd_valid_q, rd_valid_d;
   logic               err_q, err_d;
   logic               sel_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         div_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         sel_q      <= '0;
         rden_q     <= 1'b0;
         busy_q     <= 1'b0;
         csn_q      <= '1;
         sclk_q     <= 1'b0;
         sdo_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_cs_q    <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         div_q      <= div_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         sel_q      <= sel_d;
         rden_q     <= rden_d;
         busy_q     <= busy_d;
         csn_q      <= csn_d;
         sclk_q     <= sclk_d;
         sdo_q      <= sdo_d;
         rd_data_q  <= rd_data_d;
         rd_cs_q    <= rd_cs_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      div_d      = div_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      sel_d      = sel_q;
      rden_d     = rden_q;
      busy_d     = busy_q;
      csn_d      = csn_q;
      sclk_d     = sclk_q;
      sdo_d      = sdo_q;
      rd_data_d  = rd_data_q;
      rd_cs_d    = rd_cs_q;
      rd_valid_d = 1'b0;
      err_d      = err_q;
      sel_bad    = (int'(req.cs_sel_i) >= NCS);

      // Clear first so a simultaneous bad request below still leaves err set.
      if (clr_err_i) err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (req.valid_i) begin
               if (sel_bad) begin
                  err_d = 1'b1;
               end else begin
                  tx_d     = req.data_i;
                  rx_d     = '0;
                  sel_d    = req.cs_sel_i;
                  rden_d   = req.rd_en_i;
                  div_d    = spi_clk_div_i;
                  cnt_d    = CW'(spi_clk_div_i);
                  bit_d    = '0;
                  csn_d    = '1;
                  csn_d[req.cs_sel_i] = 1'b0;
                  busy_d   = 1'b1;
                  state_d  = SETUP;
               end
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = CW'(div_q);
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else if (!sclk_q) begin
               sclk_d = 1'b1;
               sdo_d  = tx_q[FRAME_W-1];
               tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
               cnt_d  = CW'(div_q);
            end else begin
               sclk_d = 1'b0;
               rx_d   = {rx_q[FRAME_W-2:0], fhd_sdi_i};
               cnt_d  = CW'(div_q);
               if (bit_q == BW'(FRAME_W - 1)) state_d = HOLD;
               else                           bit_d   = bit_q + BW'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               csn_d   = '1;
               sdo_d   = 1'b0;
               cnt_d   = CW'(CS_GAP - 1);
               state_d = GAP;
               if (rden_q) begin
                  rd_data_d  = rx_q;
                  rd_cs_d    = sel_q;
                  rd_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req.busy_o     = busy_q;
   assign req.rd_data_o  = rd_data_q;
   assign req.rd_cs_o    = rd_cs_q;
   assign req.rd_valid_o = rd_valid_q;
   assign err_o          = err_q;
   assign fhd_clk_o      = sclk_q;
   assign fhd_sdo_o      = sdo_q;
   assign fhd_csn_o      = csn_q;
endmodule

// File: tb/tb_gpa_spi_multi_iface.sv
// tb/tb_gpa_spi_multi_iface.sv - directed bench: two-CS engine with SPI slave model plus a 3-CS instance for select errors
module tb_gpa_spi_multi_iface;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gpa_spi_multi_iface_if #(.FRAME_W(24), .CSW(1)) ifa ();
   gpa_spi_multi_iface_if #(.FRAME_W(24), .CSW(2)) ifb ();

   logic [5:0] div_a, div_b;
   logic       clr_a, clr_b, err_a, err_b;
   logic       sclk_a, sdo_a, sdi_a, sclk_b, sdo_b;
   logic [1:0] csn_a;
   logic [2:0] csn_b;

   gpa_spi_multi_iface #(.NCS(2), .FRAME_W(24), .DIV_W(6), .CS_GAP(2)) dut_a (
      .clk(clk), .rst(rst), .req(ifa), .spi_clk_div_i(div_a), .clr_err_i(clr_a),
      .err_o(err_a), .fhd_clk_o(sclk_a), .fhd_sdo_o(sdo_a), .fhd_csn_o(csn_a), .fhd_sdi_i(sdi_a)
   );

   gpa_spi_multi_iface #(.NCS(3), .FRAME_W(24), .DIV_W(6), .CS_GAP(2)) dut_b (
      .clk(clk), .rst(rst), .req(ifb), .spi_clk_div_i(div_b), .clr_err_i(clr_b),
      .err_o(err_b), .fhd_clk_o(sclk_b), .fhd_sdo_o(sdo_b), .fhd_csn_o(csn_b), .fhd_sdi_i(1'b0)
   );

   int checks = 0;
   int errors = 0;

   int busy_cnt, low0, low1, rdv_cnt, rdv_coinc, viol, sclk_hi, sdo_lo_hi, hi_run, nrise;
   int b_busy, b_low;
   bit seen_frame;
   logic [1:0]  csn_prev;
   logic [23:0] slave_tx, stx, srx;
   logic [23:0] rx_q[$];
   int          gaps[$];

   always @(posedge clk) begin
      #1;
      if (ifa.busy_o) busy_cnt++;
      if (!csn_a[0]) low0++;
      if (!csn_a[1]) low1++;
      if (ifa.rd_valid_o) begin
         rdv_cnt++;
         if (csn_prev[1] == 1'b0 && csn_a[1] == 1'b1) rdv_coinc++;
      end
      if (csn_a == 2'b00) viol++;
      if (sclk_a && csn_a == 2'b11) viol++;
      if (sclk_a) begin
         sclk_hi++;
         if (!sdo_a) sdo_lo_hi++;
      end
      if (csn_a == 2'b11) begin
         hi_run++;
      end else begin
         if (seen_frame && hi_run > 0) gaps.push_back(hi_run);
         hi_run     = 0;
         seen_frame = 1'b1;
      end
      if (ifb.busy_o) b_busy++;
      if (csn_b != 3'b111) b_low++;
      csn_prev = csn_a;
   end

   wire any_low = ~&csn_a;
   always @(posedge any_low) begin
      stx = slave_tx;
      srx = '0;
   end
   always @(negedge any_low) rx_q.push_back(srx);
   always @(posedge sclk_a) begin
      nrise++;
      sdi_a = stx[23];
      stx   = {stx[22:0], 1'b0};
   end
   always @(negedge sclk_a) srx = {srx[22:0], sdo_a};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_mon();
      busy_cnt = 0; low0 = 0; low1 = 0; rdv_cnt = 0; rdv_coinc = 0; viol = 0;
      sclk_hi = 0; sdo_lo_hi = 0; hi_run = 0; nrise = 0; b_busy = 0; b_low = 0;
      seen_frame = 1'b0;
      rx_q.delete();
      gaps.delete();
   endtask

   task automatic start_a(input logic [23:0] d, input logic cs, input logic rd, input logic [5:0] div);
      int n = 0;
      while (ifa.busy_o && n < 1000) begin @(negedge clk); n++; end
      ifa.data_i   = d;
      ifa.cs_sel_i = cs;
      ifa.rd_en_i  = rd;
      div_a        = div;
      ifa.valid_i  = 1'b1;
      @(negedge clk);
      ifa.valid_i  = 1'b0;
   endtask

   task automatic wait_idle_a(input string tag);
      int n = 0;
      while (ifa.busy_o && n < 2000) begin @(negedge clk); n++; end
      chk(tag, n < 2000, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      ifa.data_i = '0; ifa.cs_sel_i = '0; ifa.rd_en_i = 1'b0; ifa.valid_i = 1'b0;
      ifb.data_i = '0; ifb.cs_sel_i = '0; ifb.rd_en_i = 1'b0; ifb.valid_i = 1'b0;
      div_a = 6'd3; div_b = 6'd3; clr_a = 1'b0; clr_b = 1'b0; sdi_a = 1'b0;
      slave_tx = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", ifa.busy_o, 0);
      chk("rst_csn", csn_a, 2'b11);
      chk("rst_sclk", sclk_a, 0);
      chk("rst_sdo", sdo_a, 0);
      chk("rst_rd_data", ifa.rd_data_o, 0);
      chk("rst_rd_cs", ifa.rd_cs_o, 0);
      chk("rst_rd_valid", ifa.rd_valid_o, 0);
      chk("rst_err", err_a, 0);
      chk("rst_err_b", err_b, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: plain write to cs0, div=3
      clr_mon();
      start_a(24'hC10000, 1'b0, 1'b0, 6'd3);
      wait_idle_a("t1_done");
      chk("t1_csn0_low", low0, 200);
      chk("t1_csn1_low", low1, 0);
      chk("t1_rises", nrise, 24);
      chk("t1_nframes", rx_q.size(), 1);
      chk("t1_rx", rx_q[0], 24'hC10000);
      chk("t1_busy", busy_cnt, 202);
      chk("t1_rdv", rdv_cnt, 0);
      chk("t1_rd_hold", ifa.rd_data_o, 0);
      chk("t1_viol", viol, 0);

      // 2: readback from cs1
      clr_mon();
      slave_tx = 24'h5A5A5A;
      start_a(24'h123456, 1'b1, 1'b1, 6'd3);
      wait_idle_a("t2_done");
      chk("t2_rd_data", ifa.rd_data_o, 24'h5A5A5A);
      chk("t2_rd_cs", ifa.rd_cs_o, 1);
      chk("t2_rdv", rdv_cnt, 1);
      chk("t2_rdv_coinc", rdv_coinc, 1);
      chk("t2_csn1_low", low1, 200);
      chk("t2_csn0_low", low0, 0);
      chk("t2_rx", rx_q[0], 24'h123456);

      // 3: valid held across three frames
      clr_mon();
      slave_tx = '0;
      ifa.data_i = 24'h000001; ifa.cs_sel_i = 1'b0; ifa.rd_en_i = 1'b0; div_a = 6'd3;
      ifa.valid_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         n = 0;
         while (!ifa.busy_o && n < 500) begin @(negedge clk); n++; end
         chk("t3_accept", n < 500, 1);
         if (k == 3) ifa.valid_i = 1'b0;
         else        ifa.data_i  = 24'(k + 1);
         n = 0;
         while (ifa.busy_o && n < 500) begin @(negedge clk); n++; end
         chk("t3_frame_end", n < 500, 1);
      end
      repeat (2) @(negedge clk);
      chk("t3_nframes", rx_q.size(), 3);
      chk("t3_rx0", rx_q[0], 24'h000001);
      chk("t3_rx1", rx_q[1], 24'h000002);
      chk("t3_rx2", rx_q[2], 24'h000003);
      chk("t3_ngaps", gaps.size(), 2);
      chk("t3_gap0", gaps[0], 3);
      chk("t3_gap1", gaps[1], 3);
      chk("t3_busy", busy_cnt, 606);
      chk("t3_viol", viol, 0);

      // 4: fastest SCLK, all ones
      clr_mon();
      start_a(24'hFFFFFF, 1'b0, 1'b0, 6'd0);
      wait_idle_a("t4_done");
      chk("t4_busy", busy_cnt, 52);
      chk("t4_sclk_hi", sclk_hi, 24);
      chk("t4_rises", nrise, 24);
      chk("t4_sdo_low_in_high", sdo_lo_hi, 0);
      chk("t4_rx", rx_q[0], 24'hFFFFFF);

      // 5: invalid select on the 3-CS instance
      clr_mon();
      ifb.cs_sel_i = 2'd3;
      ifb.valid_i  = 1'b1;
      @(negedge clk);
      ifb.valid_i  = 1'b0;
      chk("t5_err_set", err_b, 1);
      chk("t5_busy_now", ifb.busy_o, 0);
      repeat (3) @(negedge clk);
      chk("t5_busy_cnt", b_busy, 0);
      chk("t5_csn_low", b_low, 0);
      chk("t5_err_sticky", err_b, 1);
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      chk("t5_err_clr", err_b, 0);
      ifb.valid_i = 1'b1;
      clr_b       = 1'b1;
      @(negedge clk);
      ifb.valid_i = 1'b0;
      clr_b       = 1'b0;
      chk("t5_err_set_wins", err_b, 1);
      chk("t5_err_a", err_a, 0);

      // 6: reset mid-frame, then a clean frame
      clr_mon();
      start_a(24'h654321, 1'b0, 1'b1, 6'd3);
      n = 0;
      while (nrise < 10 && n < 500) begin @(negedge clk); n++; end
      chk("t6_reach10", n < 500, 1);
      rst = 1'b1;
      #1;
      chk("t6_csn", csn_a, 2'b11);
      chk("t6_sclk", sclk_a, 0);
      chk("t6_busy", ifa.busy_o, 0);
      chk("t6_sdo", sdo_a, 0);
      @(negedge clk);
      chk("t6_rdv", rdv_cnt, 0);
      rst = 1'b0;
      @(negedge clk);
      clr_mon();
      slave_tx = 24'h3C3C3C;
      start_a(24'hABCDEF, 1'b1, 1'b1, 6'd3);
      wait_idle_a("t6_done");
      chk("t6_rx", rx_q[0], 24'hABCDEF);
      chk("t6_rd_data", ifa.rd_data_o, 24'h3C3C3C);
      chk("t6_rd_cs", ifa.rd_cs_o, 1);
      chk("t6_rdv_after", rdv_cnt, 1);
      chk("t6_busy_cnt", busy_cnt, 202);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
